// File: rtl/rl_fifo_pkg.sv
// Shared helpers for the rl_fifo_1r1w FIFO controller: depth math, pointer
// difference and the status-flag bundle.
package rl_fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic int fifo_depth(input int abits);
    return 1 << abits;
  endfunction

  // Fill level from two wrap-bit pointers; result is modulo 2**(abits+1).
  function automatic logic [31:0] ptr_count(input logic [31:0] wr_ptr,
                                            input logic [31:0] rd_ptr,
                                            input int          abits);
    logic [31:0] mask;
    mask = (32'd1 << (abits + 1)) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// Simple dual-port storage macro: one write port with byte enables, one read
// port with a registered output.
module rl_ram_1r1w #(
  parameter int ABITS      = 4,
  parameter int DBITS      = 32,
  parameter     TECHNOLOGY = "GENERIC"
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [ABITS-1:0]           waddr_i,
  input  logic [DBITS-1:0]           din_i,
  input  logic [(DBITS+7)/8-1:0]     be_i,
  input  logic                       re_i,
  input  logic [ABITS-1:0]           raddr_i,
  output logic [DBITS-1:0]           dout_o
);

  logic [DBITS-1:0] mem [2**ABITS];
  logic [DBITS-1:0] bit_mask;
  logic [DBITS-1:0] wr_word;
  logic [DBITS-1:0] dout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DBITS; gi++) begin : g_bit_mask
      assign bit_mask[gi] = be_i[gi/8];
    end
  endgenerate

  assign wr_word = (mem[waddr_i] & ~bit_mask) | (din_i & bit_mask);

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wr_word;
    end
  end

  // Generic model is write-first on an address collision; other targets
  // fall back to read-old-data, which is what most vendor macros provide.
  generate
    if (TECHNOLOGY == "GENERIC") begin : g_read_write_first
      always_ff @(posedge clk_i) begin
        if (re_i) begin
          dout_reg <= (we_i && (waddr_i == raddr_i)) ? wr_word : mem[raddr_i];
        end
      end
    end else begin : g_read_old_data
      always_ff @(posedge clk_i) begin
        if (re_i) begin
          dout_reg <= mem[raddr_i];
        end
      end
    end
  endgenerate

  assign dout_o = dout_reg;

endmodule

// File: rtl/rl_fifo_1r1w.sv
// Single-clock FIFO controller around rl_ram_1r1w. Define RL_FIFO_ERR_EN to
// add sticky overflow_o / underflow_o error flags.
module rl_fifo_1r1w
  import rl_fifo_pkg::*;
#(
  parameter int ABITS                  = 4,
  parameter int DBITS                  = 32,
  parameter     TECHNOLOGY             = "GENERIC",
  parameter int ALMOST_FULL_THRESHOLD  = fifo_depth(ABITS) - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [DBITS-1:0] d_i,
  input  logic             pop_i,
  output logic [DBITS-1:0] q_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  output logic [ABITS:0]   count_o
`ifdef RL_FIFO_ERR_EN
  ,
  output logic             overflow_o,
  output logic             underflow_o
`endif
);

  localparam logic [ABITS:0] AF_LEVEL = (ABITS+1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [ABITS:0] AE_LEVEL = (ABITS+1)'(ALMOST_EMPTY_THRESHOLD);

  logic [ABITS:0]   wr_ptr_reg, wr_ptr_next;
  logic [ABITS:0]   rd_ptr_reg, rd_ptr_next;
  logic             pop_dly_reg;
  logic [DBITS-1:0] q_hold_reg;
  logic [DBITS-1:0] ram_dout;
  logic [ABITS:0]   count;
  fifo_flags_t      flags;
  logic             push_ok;
  logic             pop_ok;

  // Status decodes only from registered pointers, never from push_i/pop_i.
  assign count = (ABITS+1)'(ptr_count(32'(wr_ptr_reg), 32'(rd_ptr_reg), ABITS));

  always_comb begin
    flags              = '0;
    flags.empty        = (wr_ptr_reg == rd_ptr_reg);
    flags.full         = (wr_ptr_reg[ABITS-1:0] == rd_ptr_reg[ABITS-1:0]) &&
                         (wr_ptr_reg[ABITS] != rd_ptr_reg[ABITS]);
    flags.almost_empty = (count <= AE_LEVEL);
    flags.almost_full  = (count >= AF_LEVEL);
  end

  assign empty_o        = flags.empty;
  assign full_o         = flags.full;
  assign almost_empty_o = flags.almost_empty;
  assign almost_full_o  = flags.almost_full;
  assign count_o        = count;

  // A full FIFO refuses pushes even alongside a pop (and vice versa), so an
  // accepted read never targets the slot being written this cycle.
  assign push_ok = push_i & ~flags.full;
  assign pop_ok  = pop_i & ~flags.empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (clr_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      pop_dly_reg <= 1'b0;
      q_hold_reg  <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      pop_dly_reg <= pop_ok & ~clr_i;
      q_hold_reg  <= q_o;
    end
  end

  assign q_o = pop_dly_reg ? ram_dout : q_hold_reg;

  rl_ram_1r1w #(
    .ABITS      (ABITS),
    .DBITS      (DBITS),
    .TECHNOLOGY (TECHNOLOGY)
  ) storage (
    .clk_i   (clk_i),
    .we_i    (push_ok & ~clr_i),
    .waddr_i (wr_ptr_reg[ABITS-1:0]),
    .din_i   (d_i),
    .be_i    ('1),
    .re_i    (pop_ok & ~clr_i),
    .raddr_i (rd_ptr_reg[ABITS-1:0]),
    .dout_o  (ram_dout)
  );

`ifdef RL_FIFO_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr_i) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_i & flags.full)  overflow_reg  <= 1'b1;
      if (pop_i & flags.empty)  underflow_reg <= 1'b1;
    end
  end

  assign overflow_o  = overflow_reg;
  assign underflow_o = underflow_reg;
`endif

endmodule

// File: tb/tb_rl_fifo_1r1w.sv
// Directed plus randomized bench for rl_fifo_1r1w (ABITS=2, DBITS=8) against
// a queue-based reference model.
module tb_rl_fifo_1r1w;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       push;
  logic [7:0] d;
  logic       pop;
  logic [7:0] q;
  logic       empty, full, almost_empty, almost_full;
  logic [2:0] count;
`ifdef RL_FIFO_ERR_EN
  logic       overflow, underflow;
`endif

  rl_fifo_1r1w #(
    .ABITS                  (2),
    .DBITS                  (8),
    .TECHNOLOGY             ("GENERIC"),
    .ALMOST_FULL_THRESHOLD  (3),
    .ALMOST_EMPTY_THRESHOLD (1)
  ) dut (
    .rst_ni         (rst_n),
    .clk_i          (clk),
    .clr_i          (clr),
    .push_i         (push),
    .d_i            (d),
    .pop_i          (pop),
    .q_o            (q),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (almost_empty),
    .almost_full_o  (almost_full),
    .count_o        (count)
`ifdef RL_FIFO_ERR_EN
    ,
    .overflow_o     (overflow),
    .underflow_o    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] model_q[$];
  logic [7:0] q_exp;
  bit         ovf_exp, udf_exp;
  int         n_checks, n_err, n_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = model_q.size();
    check({ctx, ".count"}, 32'(count), 32'(n));
    check({ctx, ".empty"}, 32'(empty), 32'(n == 0));
    check({ctx, ".full"}, 32'(full), 32'(n == 4));
    check({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
    check({ctx, ".almost_full"}, 32'(almost_full), 32'(n >= 3));
    check({ctx, ".q"}, 32'(q), 32'(q_exp));
`ifdef RL_FIFO_ERR_EN
    check({ctx, ".overflow"}, 32'(overflow), 32'(ovf_exp));
    check({ctx, ".underflow"}, 32'(underflow), 32'(udf_exp));
`endif
  endtask

  // One clock with the given request; model follows the behavioural rules.
  task automatic cycle(input string ctx, input bit p, input logic [7:0] dv,
                       input bit r, input bit c);
    int n;
    push = p; d = dv; pop = r; clr = c;
    @(posedge clk);
    n = model_q.size();
    if (c) begin
      model_q.delete();
      ovf_exp = 1'b0;
      udf_exp = 1'b0;
    end else begin
      if (p && n == 4) ovf_exp = 1'b1;
      if (r && n == 0) udf_exp = 1'b1;
      if (r && n != 0) q_exp = model_q.pop_front();
      if (p && n != 4) model_q.push_back(dv);
    end
    #1;
    n_cyc++;
    $display("cyc %0d %s push=%0d d=%02h pop=%0d clr=%0d -> count=%0d q=%02h",
             n_cyc, ctx, p, dv, r, c, count, q);
    check_all(ctx);
  endtask

  initial begin
    n_checks = 0; n_err = 0; n_cyc = 0;
    q_exp = 8'h00; ovf_exp = 1'b0; udf_exp = 1'b0;
    rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Fill
    cycle("fill", 1, 8'h11, 0, 0);
    cycle("fill", 1, 8'h22, 0, 0);
    cycle("fill", 1, 8'h33, 0, 0);
    cycle("fill", 1, 8'h44, 0, 0);
    // Full reject: push dropped even with an accepted pop
    cycle("full_rej", 1, 8'h55, 1, 0);
    // Drain and hold
    cycle("drain", 0, 8'h00, 1, 0);
    cycle("drain", 0, 8'h00, 1, 0);
    cycle("drain", 0, 8'h00, 1, 0);
    cycle("hold", 0, 8'h00, 0, 0);
    cycle("hold", 0, 8'h00, 0, 0);
    // Empty reject: pop dropped even with an accepted push
    cycle("empty_rej", 1, 8'hA5, 1, 0);
    cycle("empty_rej_pop", 0, 8'h00, 1, 0);
    // Wrap: prime one entry then stream one push and one pop per cycle
    cycle("wrap_prime", 1, 8'hEE, 0, 0);
    for (int i = 0; i < 10; i++) cycle("wrap", 1, 8'(i), 1, 0);
    cycle("wrap_tail", 0, 8'h00, 1, 0);
    // Clear with push in the same cycle
    cycle("pre_clr", 1, 8'hC1, 0, 0);
    cycle("pre_clr", 1, 8'hC2, 0, 0);
    cycle("pre_clr", 1, 8'hC3, 0, 0);
    cycle("clr", 1, 8'hC4, 0, 1);
    cycle("post_clr", 0, 8'h00, 0, 0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 200; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-stream
    cycle("pre_rst", 1, 8'h71, 0, 0);
    cycle("pre_rst", 1, 8'h72, 1, 0);
    push = 1'b1; pop = 1'b1; d = 8'h73;
    #2;
    rst_n = 1'b0;
    model_q.delete();
    q_exp = 8'h00; ovf_exp = 1'b0; udf_exp = 1'b0;
    #1;
    $display("async reset asserted -> count=%0d q=%02h", count, q);
    check_all("async_rst");
    push = 1'b0; pop = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;
    cycle("after_rst", 1, 8'h81, 0, 0);
    cycle("after_rst", 0, 8'h00, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
